ramp_pwm_generator: RTL and testbench
=====================================

// Module: ramp_pwm_generator
// PURPOSE
//   Drives the ramp ADC. Produces a glitch-free PWM output whose duty steps up
//   one count after every SETTLE_PERIODS full PWM periods, forming a sawtooth
//   reference on the external RC filter. The current duty_cycle is published to
//   the comparator falling-edge capture logic. Its value at the threshold
//   crossing is the conversion result.
// PARAMETERS
//   WIDTH           8   duty/PWM counter width; PWM period = 2**WIDTH clocks
//   SETTLE_PERIODS  4   full PWM periods per duty step (RC settling), >=1
// PORTS
//   clk          in   1      system clock, all logic on posedge
//   reset_n      in   1      synchronous, active-low reset
//   enable       in   1      1 = sweep runs; 0 = idle, counters cleared
//   duty_cycle   out  WIDTH  current sawtooth duty value (registered)
//   pwm_out      out  1      PWM drive to RC filter (registered)
//   sweep_start  out  1      1-cycle pulse when a new sweep begins (duty = 0)
//   compare1     in   1      comparator output; present only with RAMP_EARLY_RESTART_EN
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): duty_cycle=0, pwm_out=0, sweep_start=0,
//     pwm_cnt=0, step_cnt=0, state=IDLE. Reset overrides every other input.
//   FSM states: IDLE and RUN.
//     IDLE -> RUN  when enable is sampled 1.
//     RUN  -> IDLE when enable is sampled 0. On that edge: pwm_cnt, step_cnt
//       and duty_cycle clear to 0; pwm_out is 0 from the next cycle.
//   Counters and flags:
//     RUN: pwm_cnt increments each clock and wraps 2**WIDTH-1 -> 0.
//     Period end: cycle where pwm_cnt == 2**WIDTH-1.
//     At each period end, step_cnt increments and wraps at SETTLE_PERIODS-1 -> 0.
//     Duty step: at a period end with step_cnt == SETTLE_PERIODS-1, duty_cycle
//       increments by 1 and wraps 2**WIDTH-1 -> 0.
//     duty_cycle changes only on period ends, so no PWM period is ever truncated.
//     sweep_start is high for the single cycle after duty_cycle wraps to 0.
//     It also pulses for the first cycle of RUN after IDLE.
//   pwm_out(t+1) = (pwm_cnt(t) < duty_cycle(t)) in RUN, else 0.
//     duty=0 gives constant low. duty=2**WIDTH-1 gives high for 2**WIDTH-1 of
//     every 2**WIDTH clocks; constant high never occurs.
//   Latency: enable sampled high at edge N -> RUN and pwm_cnt=0 at N+1.
//     First pwm_out high (if duty > 0) at N+2.
//   Full sweep length = 2**WIDTH * SETTLE_PERIODS * 2**WIDTH clocks
//     (262144 clocks at defaults).
//   enable toggled mid-period: the period is abandoned immediately. No partial
//     step is retained.
//   Arithmetic is unsigned, fixed WIDTH; no saturation, wrap only.
// CONFIGURATION
//   RAMP_EARLY_RESTART_EN defined: adds port compare1 and early restart.
//     compare1 passes through a 2-flop synchronizer. A falling edge is
//       sync_prev=1, sync=0; sync_prev resets to 1.
//     A falling edge in RUN sets restart_pend.
//     At the next period end: duty_cycle=0, step_cnt=0, sweep_start pulses,
//       restart_pend clears.
//     Further edges while restart_pend=1 are ignored.
//     restart_pend clears on IDLE or reset.
//     A natural wrap coinciding with a pending restart yields one sweep_start only.
//   RAMP_EARLY_RESTART_EN undefined: no compare1 port; sweep always runs full scale.
// TESTING (WIDTH=4, SETTLE_PERIODS=2 unless noted)
//   1. Hold reset_n=0 with enable=1 for 5 clk -> duty_cycle=0, pwm_out=0,
//      sweep_start=0 throughout.
//   2. Enable after reset -> sweep_start 1 cycle after RUN entry. duty_cycle
//      steps 0,1,2.. every 32 clk, wraps 15->0 after 512 clk with sweep_start pulse.
//   3. duty=5 period -> pwm_out high exactly 5 of 16 clk. duty=0 -> high 0/16.
//      duty=15 -> high 15/16.
//   4. Drop enable mid-period at duty=7 -> next cycle state IDLE, duty_cycle=0,
//      pwm_out=0. Re-enable -> sweep restarts from 0 with sweep_start pulse.
//   5. RAMP_EARLY_RESTART_EN: compare1 1->0 at duty=9, mid-period ->
//      duty_cycle=0 at that period end. A second edge before then has no
//      extra effect.
//   6. Defaults (WIDTH=8, SETTLE=4): sweep_start to sweep_start = 262144 clk.
//      duty_cycle never changes except on a pwm_cnt=255 cycle.

Source files
------------

// File: rtl/ramp_pwm_generator.sv
// Sawtooth PWM reference for the ramp ADC: duty steps +1 every SETTLE_PERIODS full PWM periods.
// Optional `RAMP_EARLY_RESTART_EN`: comparator falling edge restarts the sweep at the next period end.
module ramp_pwm_generator #(
    parameter int WIDTH          = 8,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
`ifdef RAMP_EARLY_RESTART_EN
    input  logic             compare1,
`endif
    output logic [WIDTH-1:0] duty_cycle,
    output logic             pwm_out,
    output logic             sweep_start
);

    localparam int STEP_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SETTLE_PERIODS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  pwm_cnt, pwm_cnt_nxt;
    logic [STEP_W-1:0] step_cnt, step_cnt_nxt;
    logic [WIDTH-1:0]  duty_nxt;
    logic              pwm_nxt;
    logic              sweep_nxt;
    logic              period_end;

    assign period_end = (pwm_cnt == {WIDTH{1'b1}});

`ifdef RAMP_EARLY_RESTART_EN
    logic cmp_meta, cmp_sync, cmp_prev;
    logic restart_pend, restart_pend_nxt;
    logic cmp_fall;

    // Synchroniser and history idle high so release from reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmp_meta     <= 1'b1;
            cmp_sync     <= 1'b1;
            cmp_prev     <= 1'b1;
            restart_pend <= 1'b0;
        end else begin
            cmp_meta     <= compare1;
            cmp_sync     <= cmp_meta;
            cmp_prev     <= cmp_sync;
            restart_pend <= restart_pend_nxt;
        end
    end

    assign cmp_fall = cmp_prev & ~cmp_sync;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            duty_cycle  <= '0;
            pwm_out     <= 1'b0;
            sweep_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            pwm_cnt     <= pwm_cnt_nxt;
            step_cnt    <= step_cnt_nxt;
            duty_cycle  <= duty_nxt;
            pwm_out     <= pwm_nxt;
            sweep_start <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pwm_cnt_nxt  = '0;
        step_cnt_nxt = '0;
        duty_nxt     = '0;
        pwm_nxt      = 1'b0;
        sweep_nxt    = 1'b0;
`ifdef RAMP_EARLY_RESTART_EN
        restart_pend_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    sweep_nxt = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Abandon the period outright; all counters already default to zero.
                    state_nxt = IDLE;
                end else begin
                    pwm_nxt      = (pwm_cnt < duty_cycle);
                    pwm_cnt_nxt  = pwm_cnt + 1'b1;
                    step_cnt_nxt = step_cnt;
                    duty_nxt     = duty_cycle;
                    if (period_end) begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt_nxt = '0;
                            duty_nxt     = duty_cycle + 1'b1;
                            sweep_nxt    = (duty_cycle == {WIDTH{1'b1}});
                        end else begin
                            step_cnt_nxt = step_cnt + 1'b1;
                        end
                    end
`ifdef RAMP_EARLY_RESTART_EN
                    restart_pend_nxt = restart_pend;
                    // A pending restart overrides the natural step; a coincident wrap still yields one pulse.
                    if (period_end && restart_pend) begin
                        duty_nxt         = '0;
                        step_cnt_nxt     = '0;
                        sweep_nxt        = 1'b1;
                        restart_pend_nxt = 1'b0;
                    end else if (cmp_fall && !restart_pend) begin
                        restart_pend_nxt = 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ramp_pwm_generator.sv
// Directed bench for ramp_pwm_generator: small instance (WIDTH=4, SETTLE=2) plus a default-sized instance.
module tb_ramp_pwm_generator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       enable8 = 1'b0;
    logic       compare1 = 1'b1;
    logic [3:0] duty_cycle;
    logic       pwm_out;
    logic       sweep_start;
    logic [7:0] duty8;
    logic       pwm8;
    logic       sweep8;

    int t;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ramp_pwm_generator #(.WIDTH(4), .SETTLE_PERIODS(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
`ifdef RAMP_EARLY_RESTART_EN
        .compare1(compare1),
`endif
        .duty_cycle(duty_cycle),
        .pwm_out(pwm_out),
        .sweep_start(sweep_start)
    );

    ramp_pwm_generator dut8 (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable8),
`ifdef RAMP_EARLY_RESTART_EN
        .compare1(1'b1),
`endif
        .duty_cycle(duty8),
        .pwm_out(pwm8),
        .sweep_start(sweep8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (duty_cycle !== 4'd0) $display("FAIL reset_duty: got %0d expected 0", duty_cycle);
            else n_pass++;
            n_checks++;
            if (pwm_out !== 1'b0) $display("FAIL reset_pwm: got %0b expected 0", pwm_out);
            else n_pass++;
            n_checks++;
            if (sweep_start !== 1'b0) $display("FAIL reset_sweep: got %0b expected 0", sweep_start);
            else n_pass++;
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (sweep_start !== 1'b0 || duty_cycle !== 4'd0)
            $display("FAIL idle_after_reset: got sweep=%0b duty=%0d expected 0/0", sweep_start, duty_cycle);
        else n_pass++;
    endtask

    task automatic test_sweep;
        int bad;
        int highs[16];
        int exp_d;
        logic exp_s, exp_p;
        bad = 0;
        for (int i = 0; i < 16; i++) highs[i] = 0;
        t = 0;
        enable = 1'b1;
        for (int k = 0; k < 520; k++) begin
            tick();
            exp_d = ((t - 1) / 32) % 16;
            exp_s = (t == 1) || (t == 513);
            exp_p = (t >= 2) ? (((t - 2) % 16) < (((t - 2) / 32) % 16)) : 1'b0;
            if (duty_cycle !== 4'(exp_d) || sweep_start !== exp_s || pwm_out !== exp_p) bad++;
            if (t >= 2 && t <= 513 && ((t - 2) % 32) < 16) highs[(t - 2) / 32] += int'(pwm_out);
            if (t == 1) begin
                n_checks++;
                if (sweep_start !== 1'b1) $display("FAIL run_entry_sweep: got %0b expected 1", sweep_start);
                else n_pass++;
            end
            if (t == 33) begin
                n_checks++;
                if (duty_cycle !== 4'd1) $display("FAIL first_step: got %0d expected 1", duty_cycle);
                else n_pass++;
            end
            if (t == 513) begin
                n_checks++;
                if (duty_cycle !== 4'd0 || sweep_start !== 1'b1)
                    $display("FAIL wrap: got duty=%0d sweep=%0b expected 0/1", duty_cycle, sweep_start);
                else n_pass++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL sweep_trace: got %0d bad cycles expected 0", bad);
        else n_pass++;
        n_checks++;
        if (highs[0] != 0) $display("FAIL duty0_highs: got %0d expected 0", highs[0]);
        else n_pass++;
        n_checks++;
        if (highs[5] != 5) $display("FAIL duty5_highs: got %0d expected 5", highs[5]);
        else n_pass++;
        n_checks++;
        if (highs[15] != 15) $display("FAIL duty15_highs: got %0d expected 15", highs[15]);
        else n_pass++;
    endtask

    task automatic test_drop;
        enable = 1'b0;
        tick();
        tick();
        t = 0;
        enable = 1'b1;
        repeat (230) tick();
        n_checks++;
        if (duty_cycle !== 4'd7) $display("FAIL pre_drop_duty: got %0d expected 7", duty_cycle);
        else n_pass++;
        enable = 1'b0;
        tick();
        n_checks++;
        if (duty_cycle !== 4'd0 || pwm_out !== 1'b0 || sweep_start !== 1'b0)
            $display("FAIL drop: got duty=%0d pwm=%0b sweep=%0b expected 0/0/0", duty_cycle, pwm_out, sweep_start);
        else n_pass++;
        tick();
        n_checks++;
        if (pwm_out !== 1'b0) $display("FAIL idle_pwm: got %0b expected 0", pwm_out);
        else n_pass++;
        t = 0;
        enable = 1'b1;
        tick();
        n_checks++;
        if (sweep_start !== 1'b1 || duty_cycle !== 4'd0)
            $display("FAIL reenable: got sweep=%0b duty=%0d expected 1/0", sweep_start, duty_cycle);
        else n_pass++;
        repeat (32) tick();
        n_checks++;
        if (duty_cycle !== 4'd1 || sweep_start !== 1'b0)
            $display("FAIL reenable_step: got duty=%0d sweep=%0b expected 1/0", duty_cycle, sweep_start);
        else n_pass++;
        enable = 1'b0;
        tick();
        tick();
    endtask

`ifdef RAMP_EARLY_RESTART_EN
    task automatic test_early_restart;
        compare1 = 1'b1;
        tick();
        tick();
        tick();
        t = 0;
        enable = 1'b1;
        for (int k = 0; k < 340; k++) begin
            tick();
            if (t == 294) begin
                n_checks++;
                if (duty_cycle !== 4'd9) $display("FAIL early_pre: got %0d expected 9", duty_cycle);
                else n_pass++;
                compare1 = 1'b0;
            end
            if (t == 296) compare1 = 1'b1;
            if (t == 298) compare1 = 1'b0;
            if (t == 304) begin
                n_checks++;
                if (duty_cycle !== 4'd9 || sweep_start !== 1'b0)
                    $display("FAIL early_hold: got duty=%0d sweep=%0b expected 9/0", duty_cycle, sweep_start);
                else n_pass++;
            end
            if (t == 305) begin
                n_checks++;
                if (duty_cycle !== 4'd0 || sweep_start !== 1'b1)
                    $display("FAIL early_restart: got duty=%0d sweep=%0b expected 0/1", duty_cycle, sweep_start);
                else n_pass++;
            end
            if (t == 306) begin
                n_checks++;
                if (sweep_start !== 1'b0) $display("FAIL early_pulse_len: got %0b expected 0", sweep_start);
                else n_pass++;
            end
            if (t == 336) begin
                n_checks++;
                if (duty_cycle !== 4'd0) $display("FAIL early_after0: got %0d expected 0", duty_cycle);
                else n_pass++;
            end
            if (t == 337) begin
                n_checks++;
                if (duty_cycle !== 4'd1) $display("FAIL early_after1: got %0d expected 1", duty_cycle);
                else n_pass++;
            end
        end
        enable = 1'b0;
        compare1 = 1'b1;
        tick();
        tick();
    endtask
`endif

    task automatic test_defaults;
        logic [7:0] prev;
        int changes;
        int first_t;
        int second_t;
        changes  = 0;
        first_t  = 0;
        second_t = 0;
        prev = duty8;
        t = 0;
        enable8 = 1'b1;
        for (int k = 0; k < 2100; k++) begin
            tick();
            if (t == 1) begin
                n_checks++;
                if (sweep8 !== 1'b1) $display("FAIL def_sweep: got %0b expected 1", sweep8);
                else n_pass++;
            end
            if (duty8 !== prev) begin
                changes++;
                if (changes == 1) first_t = t;
                if (changes == 2) second_t = t;
            end
            prev = duty8;
        end
        n_checks++;
        if (changes != 2) $display("FAIL def_changes: got %0d expected 2", changes);
        else n_pass++;
        n_checks++;
        if (first_t != 1025) $display("FAIL def_first_step: got t=%0d expected 1025", first_t);
        else n_pass++;
        n_checks++;
        if (second_t != 2049) $display("FAIL def_second_step: got t=%0d expected 2049", second_t);
        else n_pass++;
        n_checks++;
        if (duty8 !== 8'd2) $display("FAIL def_duty: got %0d expected 2", duty8);
        else n_pass++;
        enable8 = 1'b0;
        tick();
    endtask

    initial begin
        t = 0;
        test_reset();
        test_sweep();
        test_drop();
`ifdef RAMP_EARLY_RESTART_EN
        test_early_restart();
`endif
        test_defaults();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
